// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encodings, requester IDs and default parameters shared by
// the mem_arbiter block and its winner-selection helper.
package mem_arb_pkg;

    // Controller states (2-bit encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Requester IDs
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_IO  = 1'b1;

    // Default parameter values
    localparam int unsigned DEF_DATA_W = 14;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_RD_LAT = 2;

    // Read-latency counter width; covers RD_LAT up to 15
    localparam int unsigned CNT_W = 4;

    // One-hot strobe for a requester ID
    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way winner selection. A lone requester wins
// outright; on a tie the requester not served last wins. When
// MEM_ARB_LOCK_EN is defined, a held lock overrides the round-robin choice
// if the locked requester is asking.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_id_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic       lock_vld_i,
    input  logic       lock_id_i,
`endif
    output logic       winner_o
);

    // Winner decode from the request vector and round-robin pointer
    always_comb begin
        winner_o = ID_CPU;
        case (req_i)
            2'b01:   winner_o = ID_CPU;
            2'b10:   winner_o = ID_IO;
            2'b11:   winner_o = ~last_id_i;
            default: winner_o = ID_CPU;
        endcase
`ifdef MEM_ARB_LOCK_EN
        if (lock_vld_i && req_i[lock_id_i]) begin
            winner_o = lock_id_i;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU / I/O) arbiter in front of a single-port RAM
// with fixed read latency. One access at a time: IDLE arbitrates, ISSUE drives
// the RAM strobe for one cycle, WAIT counts down the read latency and captures
// the read data. Optional macro MEM_ARB_LOCK_EN adds a 'lock' input that lets
// the last winner keep the bus on the next arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in
`ifdef MEM_ARB_LOCK_EN
    ,
    input  logic [1:0]        lock
`endif
);

    // WAIT runs RD_LAT cycles; the counter hits 0 in the capture cycle
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_id_q, last_id_d;
    logic              win_q, win_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick;
`ifdef MEM_ARB_LOCK_EN
    logic              lock_vld_q, lock_vld_d;
    logic              lock_id_q, lock_id_d;
`endif

    rr_pick2 u_rr_pick2 (
        .req_i      (req),
        .last_id_i  (last_id_q),
`ifdef MEM_ARB_LOCK_EN
        .lock_vld_i (lock_vld_q),
        .lock_id_i  (lock_id_q),
`endif
        .winner_o   (pick)
    );

    // Next-state: arbitration in IDLE preloads the ISSUE-cycle outputs so the
    // strobes, grant and address come straight from flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_id_d  = last_id_q;
        win_d      = win_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        ram_rd_d   = 1'b0;
        ram_wr_d   = 1'b0;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    win_d      = pick;
                    gnt_d      = id_onehot(pick);
                    addr_out_d = pick ? addr1 : addr0;
                    if (we[pick]) begin
                        ram_wr_d   = 1'b1;
                        data_out_d = pick ? wdata1 : wdata0;
                    end else begin
                        ram_rd_d = 1'b1;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                last_id_d = win_q;
`ifdef MEM_ARB_LOCK_EN
                lock_vld_d = lock[win_q];
                lock_id_d  = win_q;
`endif
                if (ram_wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = data_in;
                    rvalid_d = id_onehot(win_q);
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_id_q  <= ID_IO;
            win_q      <= ID_CPU;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= '0;
            rdata_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_id_q  <= ID_CPU;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_id_q  <= last_id_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            ram_rd_q   <= ram_rd_d;
            ram_wr_q   <= ram_wr_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign ram_rd   = ram_rd_q;
    assign ram_wr   = ram_wr_q;
    assign addr_out = addr_out_q;
    assign data_out = data_out_q;

endmodule
